// File: rtl/game_pkg.sv
// game_pkg: stage codes and per-stage kill caps shared by the tracker and the stage controller
package game_pkg;
  localparam logic [3:0] STAGE_TITLE = 4'h0;
  localparam logic [3:0] STAGE_WIN   = 4'hE;
  localparam logic [3:0] STAGE_LOSE  = 4'hF;
  localparam logic [3:0] STAGE_LAST  = 4'h5;
  function automatic logic [3:0] kill_cap(input logic [3:0] stage);
    return stage == 4'h1 ? 4'd2 :
           stage == 4'h2 ? 4'd4 :
           stage == 4'h3 ? 4'd6 :
           stage == 4'h4 ? 4'd8 :
           stage == 4'h5 ? 4'd9 : 4'd0;
  endfunction
endpackage

// File: rtl/combat_tracker_invuln_timer.sv
// invuln_timer: 8-bit down-counter for the post-hit invulnerability window
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the count
//   load     : load CYCLES
//   tick     : allow counting down (low while the game is frozen so invuln holds)
//   busy     : count != 0
module invuln_timer #(
  parameter int CYCLES = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic tick,
  output logic busy
);
  logic [7:0] count_q, count_d;
  always_comb begin
    count_d = clear ? 8'd0 :
              load ? 8'(CYCLES) :
              (tick && count_q != 8'd0) ? count_q - 8'd1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) count_q <= 8'd0;
    else     count_q <= count_d;
  end
  assign busy = count_q != 8'd0;
endmodule

// File: rtl/combat_tracker.sv
// combat_tracker: counts kills (capped per stage) and tracks player HP, gameover and invulnerability
//   clk, rst        : clock, synchronous active-high reset
//   stage           : current stage code from the stage controller
//   changing_stage  : pulse in the first cycle of a new stage
//   enemy_killed    : pulse per enemy destroyed
//   player_hit      : pulse per collision with the player
//   kills, hp       : registered kill count and HP
//   gameover        : sticky, set when HP reaches 0, cleared on the title stage
//   invuln          : post-hit invulnerability window active
//   HEAL_ON_CLEAR_EN: when defined, entering stages 2..5 restores one HP
module combat_tracker
  import game_pkg::*;
#(
  parameter  int HP_MAX        = 3,
  parameter  int INVULN_CYCLES = 50,
  localparam int HP_W          = $clog2(HP_MAX + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      stage,
  input  logic            changing_stage,
  input  logic            enemy_killed,
  input  logic            player_hit,
  output logic [3:0]      kills,
  output logic [HP_W-1:0] hp,
  output logic            gameover,
  output logic            invuln
);
  logic [3:0]      kills_q, kills_d;
  logic [HP_W-1:0] hp_q, hp_d, hp_dec;
  logic            gameover_q, gameover_d;
  logic            title, play, active, kill_ok, hit_ok, heal;
  always_comb begin
    title   = stage == STAGE_TITLE;
    play    = stage >= 4'h1 && stage <= STAGE_LAST;
    active  = play && !gameover_q && !changing_stage;
    kill_ok = active && enemy_killed && kills_q < kill_cap(stage);
    hit_ok  = active && player_hit && !invuln;
`ifdef HEAL_ON_CLEAR_EN
    heal    = changing_stage && stage >= 4'h2 && stage <= STAGE_LAST && hp_q < HP_W'(HP_MAX);
`else
    heal    = 1'b0;
`endif
    hp_dec     = hp_q == '0 ? '0 : hp_q - HP_W'(1);
    kills_d    = title ? 4'd0 : kill_ok ? kills_q + 4'd1 : kills_q;
    hp_d       = title ? HP_W'(HP_MAX) : hit_ok ? hp_dec : heal ? hp_q + HP_W'(1) : hp_q;
    gameover_d = title ? 1'b0 : gameover_q | (hit_ok && hp_dec == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      kills_q    <= 4'd0;
      hp_q       <= HP_W'(HP_MAX);
      gameover_q <= 1'b0;
    end else begin
      kills_q    <= kills_d;
      hp_q       <= hp_d;
      gameover_q <= gameover_d;
    end
  end
  // the timer only runs in playable stages so the window freezes with everything else
  invuln_timer #(.CYCLES(INVULN_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(title),
    .load (hit_ok),
    .tick (play),
    .busy (invuln)
  );
  assign kills    = kills_q;
  assign hp       = hp_q;
  assign gameover = gameover_q;
endmodule

// File: tb/tb_combat_tracker.sv
// tb_combat_tracker: directed scenarios plus random play checked every cycle against a behavioural model
module tb_combat_tracker;
  localparam int HP_MAX = 3;
  localparam int INV    = 50;
  localparam int HP_W   = $clog2(HP_MAX + 1);
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      stage = 4'h0;
  logic            changing_stage = 1'b0;
  logic            enemy_killed = 1'b0;
  logic            player_hit = 1'b0;
  logic [3:0]      kills;
  logic [HP_W-1:0] hp;
  logic            gameover;
  logic            invuln;
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int m_kills = 0, m_hp = HP_MAX, m_timer = 0;
  bit m_go    = 1'b0;

  combat_tracker #(.HP_MAX(HP_MAX), .INVULN_CYCLES(INV)) dut (
    .clk(clk), .rst(rst), .stage(stage), .changing_stage(changing_stage),
    .enemy_killed(enemy_killed), .player_hit(player_hit),
    .kills(kills), .hp(hp), .gameover(gameover), .invuln(invuln)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // model: game rules stated directly, invulnerability as "cycles remaining"
  always @(posedge clk) begin
    int k, h, t, cap;
    bit g, act;
    k = m_kills; h = m_hp; t = m_timer; g = m_go;
    if (rst || stage == 4'h0) begin
      k = 0; h = HP_MAX; t = 0; g = 0;
    end else if (stage >= 4'h1 && stage <= 4'h5) begin
      cap = (stage == 4'h5) ? 9 : 2 * int'(stage);
      act = !g && !changing_stage;
      if (act && enemy_killed && k < cap) k++;
      if (act && player_hit && t == 0) begin
        h = (h > 0) ? h - 1 : 0;
        if (h == 0) g = 1;
        t = INV;
      end else if (t > 0) t--;
`ifdef HEAL_ON_CLEAR_EN
      if (changing_stage && stage >= 4'h2 && h < HP_MAX) h++;
`endif
    end
    m_kills <= k; m_hp <= h; m_timer <= t; m_go <= g;
  end

  always @(negedge clk) if (chk_en) begin
    chk("kills", int'(kills), m_kills);
    chk("hp", int'(hp), m_hp);
    chk("gameover", int'(gameover), int'(m_go));
    chk("invuln", int'(invuln), int'(m_timer > 0));
  end

  // one cycle of stimulus; returns just after the capturing edge
  task automatic drive(input logic [3:0] s, input bit chg, input bit k, input bit h);
    @(negedge clk); #1;
    stage = s; changing_stage = chg; enemy_killed = k; player_hit = h;
    @(posedge clk); #1;
    changing_stage = 0; enemy_killed = 0; player_hit = 0;
  endtask

  task automatic wait_invuln(input logic [3:0] s);
    int i;
    for (i = 0; i < 100 && invuln; i++) drive(s, 0, 0, 0);
    if (invuln) begin
      n_tests++; n_fail++;
      $display("FAIL invuln_timeout: invuln still 1 after 100 cycles");
    end
  endtask

  initial begin
    int cnt;
    int exp_k [3] = '{1, 2, 2};
    int exp_k2[3] = '{3, 4, 4};
    repeat (2) @(posedge clk);
    #1 rst = 0; chk_en = 1;
    chk("rst_kills", kills, 0); chk("rst_hp", hp, 3);
    chk("rst_go", gameover, 0); chk("rst_inv", invuln, 0);
    drive(4'h1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin drive(4'h1, 0, 1, 0); chk("kill_s1", kills, exp_k[i]); end
    drive(4'h2, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin drive(4'h2, 0, 1, 0); chk("kill_s2", kills, exp_k2[i]); end
    drive(4'h1, 0, 0, 1);
    chk("hit_hp", hp, 2);
    cnt = invuln ? 1 : 0;
    for (int i = 0; i < 9; i++) begin drive(4'h1, 0, 0, 0); cnt += invuln ? 1 : 0; end
    drive(4'h1, 0, 0, 1);
    cnt += invuln ? 1 : 0;
    chk("hit_in_window", hp, 2);
    for (int i = 0; i < 100 && invuln; i++) begin drive(4'h1, 0, 0, 0); cnt += invuln ? 1 : 0; end
    chk("invuln_len", cnt, 50);
    drive(4'h1, 0, 0, 1);
    chk("hit_after_window", hp, 1);
    drive(4'h3, 1, 0, 0);
    wait_invuln(4'h3);
    drive(4'h3, 0, 1, 1);
    chk("fatal_hp", hp, 0); chk("fatal_go", gameover, 1); chk("fatal_kill", kills, 5);
    drive(4'h3, 0, 1, 1);
    chk("go_ign_k", kills, 5); chk("go_ign_hp", hp, 0);
    drive(4'hF, 1, 1, 1);
    drive(4'hF, 0, 1, 1);
    chk("lose_hold_k", kills, 5); chk("lose_hold_go", gameover, 1);
    drive(4'h0, 1, 0, 0);
    chk("title_hp", hp, 3); chk("title_k", kills, 0); chk("title_go", gameover, 0); chk("title_inv", invuln, 0);
    drive(4'h2, 1, 1, 1);
    chk("chg_drop_k", kills, 0); chk("chg_drop_hp", hp, 3);
    drive(4'h2, 0, 0, 1);
    chk("s2_hit", hp, 2);
    wait_invuln(4'h2);
    drive(4'h3, 1, 1, 1);
    chk("chg_drop_k2", kills, 0);
`ifdef HEAL_ON_CLEAR_EN
    chk("heal", hp, 3);
`else
    chk("no_heal", hp, 2);
`endif
    drive(4'h4, 1, 0, 0);
`ifdef HEAL_ON_CLEAR_EN
    chk("heal_sat", hp, 3);
`else
    chk("no_heal2", hp, 2);
`endif
    drive(4'h0, 0, 0, 0);
    drive(4'h5, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(4'h5, 0, 1, 0);
    drive(4'h5, 0, 0, 1);
    wait_invuln(4'h5);
    drive(4'h5, 0, 0, 1);
    chk("pre_rst_k", kills, 5); chk("pre_rst_hp", hp, 1); chk("pre_rst_inv", invuln, 1);
    rst = 1;
    drive(4'h5, 0, 0, 0);
    rst = 0;
    chk("mid_rst_k", kills, 0); chk("mid_rst_hp", hp, 3);
    chk("mid_rst_go", gameover, 0); chk("mid_rst_inv", invuln, 0);
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [3:0] s;
      r = $urandom_range(0, 99);
      s = (r < 3) ? 4'h0 : (r < 5) ? 4'hF : (r < 7) ? 4'hE : (r < 8) ? 4'h9 : 4'($urandom_range(1, 5));
      rst = ($urandom_range(0, 299) == 0);
      drive(s, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
      rst = 0;
    end
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
